// File: rtl/btn_debounce_if.sv
// Button debouncer signal bundle: sample strobe source and raw inputs in,
// debounced level plus press/release pulses out.
interface btn_debounce_if #(
    parameter int NBTN = 5
);
    logic            tick_src;
    logic [NBTN-1:0] btn_in;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_release;

    // Plain level signals, no valid/ready: outputs are registered and the
    // press/release pulses are exactly one clk wide, consumers sample every clk.
    modport master (
        output tick_src,
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  tick_src,
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_debounce.sv
// Per-channel push-button debouncer with press/release edge pulses. Samples a
// two-flop synchronized copy of each input on every rising edge of tick_src.
module btn_debounce #(
    parameter int NBTN   = 5,
    parameter int STABLE = 4,
    parameter int CW     = 4
) (
    input  logic           clk,
    input  logic           rst,
    btn_debounce_if.slave  bus
);
    localparam logic [CW:0] STABLE_C = (CW+1)'(STABLE);
    localparam logic [CW:0] ONE_C    = (CW+1)'(1);

    logic            r_tick_q;
    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [NBTN-1:0] r_level;
    logic [NBTN-1:0] r_press;
    logic [NBTN-1:0] r_release;
    logic [CW-1:0]   r_cnt [NBTN];

    logic            w_tick;
    logic [NBTN-1:0] w_level_nxt;
    logic [NBTN-1:0] w_press_nxt;
    logic [NBTN-1:0] w_release_nxt;
    logic [CW-1:0]   w_cnt_nxt [NBTN];

    // tick_src comes from the clkdiv counter in this clock domain, so it is
    // edge-detected directly without resynchronization.
    assign w_tick = bus.tick_src & ~r_tick_q;

    always_comb begin
        w_level_nxt   = r_level;
        w_press_nxt   = '0;
        w_release_nxt = '0;
        for (int i = 0; i < NBTN; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_tick) begin
                if (r_sync2[i] == r_level[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (({1'b0, r_cnt[i]} + ONE_C) == STABLE_C) begin
                    w_cnt_nxt[i]     = '0;
                    w_level_nxt[i]   = r_sync2[i];
                    w_press_nxt[i]   = r_sync2[i];
                    w_release_nxt[i] = ~r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // tick_q resets high so a tick_src already high at reset release is not a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_q  <= 1'b1;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < NBTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_tick_q  <= bus.tick_src;
            r_sync1   <= bus.btn_in;
            r_sync2   <= r_sync1;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            for (int i = 0; i < NBTN; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign bus.btn_level   = r_level;
    assign bus.btn_press   = r_press;
    assign bus.btn_release = r_release;
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: STABLE=4 and STABLE=1 instances on shared stimulus,
// compared every cycle against a sample-window reference model.
module tb_btn_debounce;
  localparam int NBTN = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            tick_src = 1'b1;
  logic [NBTN-1:0] btn_in   = '0;

  btn_debounce_if #(.NBTN(NBTN)) bus_a ();
  btn_debounce_if #(.NBTN(NBTN)) bus_b ();

  assign bus_a.tick_src = tick_src;
  assign bus_a.btn_in   = btn_in;
  assign bus_b.tick_src = tick_src;
  assign bus_b.btn_in   = btn_in;

  btn_debounce #(.NBTN(NBTN), .STABLE(4), .CW(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  btn_debounce #(.NBTN(NBTN), .STABLE(1), .CW(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // ---------------- reference model ----------------
  // A channel's level flips when the last STABLE tick samples all disagree with it.
  logic            m_tickq = 1'b1;
  logic [NBTN-1:0] m_p1 = '0;
  logic [NBTN-1:0] m_p2 = '0;
  logic [NBTN-1:0] m_level [2];
  logic [NBTN-1:0] m_press [2];
  logic [NBTN-1:0] m_rel   [2];
  logic [15:0]     m_win   [2][NBTN];
  int              m_seen  [2][NBTN];

  function automatic int stab_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) begin : model
    logic            tk;
    logic [NBTN-1:0] s2;
    logic [15:0]     mask;
    logic            hit;
    if (rst) begin
      m_tickq = 1'b1;
      m_p1 = '0;
      m_p2 = '0;
      for (int k = 0; k < 2; k++) begin
        m_level[k] = '0; m_press[k] = '0; m_rel[k] = '0;
        for (int i = 0; i < NBTN; i++) begin
          m_win[k][i] = '0; m_seen[k][i] = 0;
        end
      end
    end else begin
      tk = tick_src & ~m_tickq;
      m_tickq = tick_src;
      s2 = m_p2;
      m_p2 = m_p1;
      m_p1 = btn_in;
      for (int k = 0; k < 2; k++) begin
        m_press[k] = '0;
        m_rel[k]   = '0;
        if (tk) begin
          mask = (16'd1 << stab_of(k)) - 16'd1;
          for (int i = 0; i < NBTN; i++) begin
            m_win[k][i] = {m_win[k][i][14:0], s2[i]};
            if (m_seen[k][i] < 16) m_seen[k][i]++;
            hit = m_level[k][i] ? ((m_win[k][i] & mask) == 16'd0)
                                : ((m_win[k][i] & mask) == mask);
            if (m_seen[k][i] >= stab_of(k) && hit) begin
              m_level[k][i] = ~m_level[k][i];
              if (m_level[k][i]) m_press[k][i] = 1'b1;
              else               m_rel[k][i]   = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int pcnt [NBTN];
  int rcnt [NBTN];
  int pcyc [NBTN];
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NBTN; i++) begin
      pcnt[i] = 0; rcnt[i] = 0; pcyc[i] = -1;
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [7:0] div = 8'd8;

  task automatic step();
    @(negedge clk);
    cyc++;
    check_eq("a_level",   32'(bus_a.btn_level),   32'(m_level[0]));
    check_eq("a_press",   32'(bus_a.btn_press),   32'(m_press[0]));
    check_eq("a_release", 32'(bus_a.btn_release), 32'(m_rel[0]));
    check_eq("b_level",   32'(bus_b.btn_level),   32'(m_level[1]));
    check_eq("b_press",   32'(bus_b.btn_press),   32'(m_press[1]));
    check_eq("b_release", 32'(bus_b.btn_release), 32'(m_rel[1]));
    check_eq("a_both",    32'(bus_a.btn_press & bus_a.btn_release), 32'(0));
    for (int i = 0; i < NBTN; i++) begin
      if (bus_a.btn_press[i]) begin pcnt[i]++; pcyc[i] = cyc; end
      if (bus_a.btn_release[i]) rcnt[i]++;
    end
  endtask

  task automatic step_div();
    step();
    div = div + 8'd1;
    tick_src = div[3];
  endtask

  // Advance n tick periods (a strobe happens at phase 8), stopping at phase 12.
  task automatic wait_ticks(input int n);
    int seen;
    seen = 0;
    while (seen < n) begin
      step_div();
      if (div[3:0] == 4'd12) seen++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tcnt;
    clear_counts();
    // Reset with tick_src held high
    rst = 1'b1; tick_src = 1'b1; btn_in = '0;
    repeat (3) step();
    check_eq("rst_level", 32'(bus_a.btn_level), 32'(0));
    check_eq("rst_press", 32'(bus_a.btn_press | bus_a.btn_release), 32'(0));
    rst = 1'b0;
    btn_in = '1;
    // tick_src stays high until div 16; no strobe may occur before div reaches 24.
    repeat (14) step_div();
    check_eq("no_early_tick", 32'(bus_b.btn_level), 32'(0));
    btn_in = '0;
    wait_ticks(2);
    clear_counts();

    // Clean press on channel 0
    btn_in[0] = 1'b1;
    wait_ticks(3);
    check_eq("press_lvl_3", 32'(bus_a.btn_level), 32'h00);
    wait_ticks(1);
    check_eq("press_lvl_4", 32'(bus_a.btn_level), 32'h01);
    wait_ticks(1);
    check_eq("press_cnt0", 32'(pcnt[0]), 32'(1));
    check_eq("press_rel0", 32'(rcnt[0]), 32'(0));

    // Bounce on channel 1
    clear_counts();
    btn_in[1] = 1'b1; wait_ticks(3);
    check_eq("bounce_hold3", 32'(bus_a.btn_level[1]), 32'(0));
    btn_in[1] = 1'b0; wait_ticks(1);
    btn_in[1] = 1'b1; wait_ticks(3);
    check_eq("bounce_again3", 32'(bus_a.btn_level[1]), 32'(0));
    wait_ticks(1);
    check_eq("bounce_accept", 32'(bus_a.btn_level[1]), 32'(1));
    check_eq("bounce_pcnt", 32'(pcnt[1]), 32'(1));

    // Release on channel 2
    btn_in[2] = 1'b1; wait_ticks(5);
    clear_counts();
    btn_in[2] = 1'b0; wait_ticks(3);
    check_eq("rel_hold3", 32'(bus_a.btn_level[2]), 32'(1));
    wait_ticks(1);
    check_eq("rel_accept", 32'(bus_a.btn_level[2]), 32'(0));
    check_eq("rel_rcnt", 32'(rcnt[2]), 32'(1));
    check_eq("rel_pcnt", 32'(pcnt[2]), 32'(0));

    // Simultaneous press on channels 4:3
    clear_counts();
    btn_in[4:3] = 2'b11; wait_ticks(5);
    check_eq("sim_pcnt3", 32'(pcnt[3]), 32'(1));
    check_eq("sim_pcnt4", 32'(pcnt[4]), 32'(1));
    check_eq("sim_same_clk", 32'(pcyc[4] - pcyc[3]), 32'(0));
    btn_in[4:3] = 2'b00; wait_ticks(5);

    // Mid-count reset
    clear_counts();
    btn_in[4:3] = 2'b11; wait_ticks(2);
    rst = 1'b1; step_div(); step_div();
    rst = 1'b0; step_div();
    check_eq("mrst_level", 32'(bus_a.btn_level), 32'(0));
    wait_ticks(3);
    check_eq("mrst_nopulse", 32'(pcnt[3] + pcnt[4]), 32'(0));
    wait_ticks(2);
    check_eq("mrst_lvl43", 32'(bus_a.btn_level[4:3]), 32'(3));
    check_eq("mrst_pcnt", 32'(pcnt[3] + pcnt[4]), 32'(2));

    // Glitch between ticks on channel 0
    btn_in[0] = 1'b0; wait_ticks(5);
    clear_counts();
    while (div[3:0] != 4'd10) step_div();
    btn_in[0] = 1'b1;
    repeat (3) step_div();
    btn_in[0] = 1'b0;
    wait_ticks(3);
    check_eq("glitch_lvl_a", 32'(bus_a.btn_level[0]), 32'(0));
    check_eq("glitch_lvl_b", 32'(bus_b.btn_level[0]), 32'(0));
    check_eq("glitch_pcnt",  32'(pcnt[0]), 32'(0));

    // Randomized phase: random tick periods, random flips, occasional reset
    tcnt = 1;
    for (int c = 0; c < 4000; c++) begin
      step();
      tcnt--;
      if (tcnt == 0) begin
        tick_src = ~tick_src;
        tcnt = $urandom_range(1, 6);
      end
      for (int i = 0; i < NBTN; i++) begin
        if ($urandom_range(0, ((c / 500) % 2 == 0) ? 20 : 200) == 0) btn_in[i] = ~btn_in[i];
      end
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    step();

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
